move_scheduler: RTL and testbench
=================================

# move_scheduler

Sequencing and arbitration front-end for the AXI-MM block-copy engine `data_mover`. It accepts move descriptors from NREQ independent requesters and grants them round-robin. It validates each descriptor, drives the mover's control inputs (`src_address`, `dst_address`, `byte_count`, `burst_size`, `start`), waits for `idle`, and returns a per-move completion with status. It sits between the software/DMA-request logic and exactly one `data_mover` instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 512, data width of the attached mover, in bits; sets the minimum legal burst size to DW/8 bytes

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset (one clock; async assert)
- enable  in  1  when 0, no new grants; an in-flight move completes normally
- req_valid  in  NREQ  per-requester descriptor valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_src  in  NREQ*64  source byte address; slice i belongs to requester i
- req_dst  in  NREQ*64  destination byte address
- req_count  in  NREQ*64  byte count
- req_burst  in  NREQ*13  burst size in bytes
- done_valid  out  1  one-cycle completion pulse
- done_id  out  $clog2(NREQ)  requester index of the completed move
- done_err  out  1  1 = descriptor rejected, no data moved
- moves_done  out  32  count of successful moves; wraps at 2^32
- busy  out  1  state != IDLE
- dm_src_address, dm_dst_address, dm_byte_count  out  64  to mover
- dm_burst_size  out  13  to mover
- dm_start  out  1  to mover; one-cycle pulse
- dm_idle  in  1  from mover

## Operation
- FSM states: IDLE, START, WAIT, DONE.
- **IDLE:**
  - Grant g is the first requester with `req_valid` high, searching upward from `rr_ptr` with wrap.
  - If `enable` is high and any request is valid, `req_ready[g]=1`. The handshake captures g's descriptor into registers, sets `done_id=g`, and sets `rr_ptr=(g+1)%NREQ`.
  - If the descriptor is legal, go to START; otherwise set `err=1` and go to DONE.
- **Legal descriptor**, all of the following:
  - burst is a power of two, with DW/8 ≤ burst ≤ 4096;
  - count ≠ 0;
  - count % burst == 0;
  - count/burst < 2^32.
- **START:** `dm_start=1` for exactly one cycle, then go to WAIT.
- **WAIT:** stay until `dm_idle==1`, then go to DONE.
  - `dm_idle` is ignored in the START cycle.
  - The mover reports idle=0 from the start cycle onward.
- **DONE:** `done_valid=1` for one cycle, with `done_err=err`. If `err==0`, `moves_done` increments. Then go to IDLE.
- The `dm_*` data outputs are registered.
  - They change only on an IDLE acceptance of a legal descriptor.
  - They hold stable from START through DONE, because the mover uses `byte_count` and `burst_size` combinationally for the whole move.
  - Rejected descriptors leave them unchanged.
- If `req_valid` drops without a handshake, nothing is captured. Requesters must hold their fields stable while valid.

## Timing
- Reset values: all outputs 0 (`dm_*`, `done_*`, `req_ready`, `moves_done`, `busy`); state IDLE; `rr_ptr=0`.
- `req_ready` is combinational from state, `enable`, `req_valid` and `rr_ptr`. All other outputs are registered.
- Accept at cycle T:
  - `dm_start` at T+1.
  - `done_valid` one cycle after the first cycle of WAIT in which `dm_idle=1`.
  - Rejected descriptor: `done_valid` at T+1.
- Throughput: at most one move in flight. A new accept is possible the cycle after DONE.
- Simultaneous valids: round-robin fairness. A requester waits at most NREQ-1 grants.
- `enable` deasserted in START, WAIT or DONE has no effect until the return to IDLE.
- Reset mid-move: everything returns to reset values immediately and no completion is emitted. The mover must be reset in the same reset domain.
- `moves_done` wraps 0xFFFFFFFF → 0.

## Structure
- Shared package/include holds: state encodings, `MAX_BURST=4096`, and the `burst_legal()` function (power-of-two and range check).
- One natural sub-module: `rr_arbiter` (NREQ-wide request vector plus pointer in; one-hot grant plus index out; purely combinational).
- The count/burst divisibility check uses a case on burst size with shift/mask, not a divider.

## Test plan
- **Single legal move:** req0 with src=0x1000, dst=0x8000, count=4096, burst=1024.
  - `dm_start` pulses at T+1 with those values.
  - Model `dm_idle` low for 20 cycles: then `done_valid` with id=0, err=0, and `moves_done=1`.
- **Round-robin:** all 4 requesters valid continuously.
  - Grant order is 0,1,2,3,0.
  - `dm_*` stay stable through each WAIT.
- **Rejects, no `dm_start`, each with `done_err=1` at T+1 and `moves_done` unchanged:**
  - count=100, burst=64
  - burst=96
  - burst=32 with DW=512
  - count=0
- **enable gating:** `enable=0` while req2 is valid.
  - No `req_ready`.
  - Raise `enable`: accepted next cycle.
- **Reset mid-WAIT:** assert `resetn=0`.
  - Outputs are 0 immediately, with no `done_valid`.
  - After release, the next request is served from `rr_ptr=0`.
- **Counter wrap:** preload `moves_done` to 0xFFFFFFFF via force, run one legal move.
  - `moves_done=0`.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared types and helpers for the move_scheduler front-end:
// FSM encoding, burst limits and the burst legality check.
package move_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int MAX_BURST = 4096;

    // Burst must be a non-zero power of two within [min_burst, MAX_BURST].
    function automatic logic burst_legal(input logic [12:0] burst, input int min_burst);
        return (burst != '0)
            && ((burst & (burst - 13'd1)) == '0)
            && (int'(burst) >= min_burst)
            && (int'(burst) <= MAX_BURST);
    endfunction

endpackage

// File: rtl/move_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// above ptr, wrapping, and returns it one-hot and as an index.
module rr_arbiter
    import move_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates move descriptors from NREQ requesters, validates them, drives
// one data_mover through a start/idle handshake and reports completion.
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 512,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*64-1:0] req_src,
    input  logic [NREQ*64-1:0] req_dst,
    input  logic [NREQ*64-1:0] req_count,
    input  logic [NREQ*13-1:0] req_burst,
    output logic              done_valid,
    output logic [IW-1:0]     done_id,
    output logic              done_err,
    output logic [31:0]       moves_done,
    output logic              busy,
    output logic [63:0]       dm_src_address,
    output logic [63:0]       dm_dst_address,
    output logic [63:0]       dm_byte_count,
    output logic [12:0]       dm_burst_size,
    output logic              dm_start,
    input  logic              dm_idle
);

    // Divisibility and beat-count range via shift/mask on the burst exponent.
    function automatic logic count_ok(input logic [63:0] count, input logic [12:0] burst);
        logic [3:0] sh;
        logic       hit;
        sh  = '0;
        hit = 1'b1;
        case (burst)
            13'd1:    sh = 4'd0;
            13'd2:    sh = 4'd1;
            13'd4:    sh = 4'd2;
            13'd8:    sh = 4'd3;
            13'd16:   sh = 4'd4;
            13'd32:   sh = 4'd5;
            13'd64:   sh = 4'd6;
            13'd128:  sh = 4'd7;
            13'd256:  sh = 4'd8;
            13'd512:  sh = 4'd9;
            13'd1024: sh = 4'd10;
            13'd2048: sh = 4'd11;
            13'd4096: sh = 4'd12;
            default:  hit = 1'b0;
        endcase
        return hit
            && ((count & ((64'd1 << sh) - 64'd1)) == '0)
            && ((count >> (6'd32 + 6'(sh))) == '0);
    endfunction

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   g_idx;
    logic [NREQ-1:0] g_onehot;
    logic            g_any;
    logic            accept;
    logic            legal;
    logic [63:0]     sel_src, sel_dst, sel_count;
    logic [12:0]     sel_burst;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (g_onehot),
        .idx   (g_idx),
        .any   (g_any)
    );

    assign sel_src   = req_src[int'(g_idx)*64 +: 64];
    assign sel_dst   = req_dst[int'(g_idx)*64 +: 64];
    assign sel_count = req_count[int'(g_idx)*64 +: 64];
    assign sel_burst = req_burst[int'(g_idx)*13 +: 13];

    assign legal = burst_legal(sel_burst, DW/8)
                && (sel_count != '0)
                && count_ok(sel_count, sel_burst);

    assign accept    = (state == ST_IDLE) && enable && g_any;
    assign req_ready = accept ? g_onehot : '0;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (accept) state_n = legal ? ST_START : ST_DONE;
            ST_START: state_n = ST_WAIT;
            ST_WAIT:  if (dm_idle) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            done_id        <= '0;
            done_valid     <= 1'b0;
            done_err       <= 1'b0;
            moves_done     <= '0;
            busy           <= 1'b0;
            dm_start       <= 1'b0;
            dm_src_address <= '0;
            dm_dst_address <= '0;
            dm_byte_count  <= '0;
            dm_burst_size  <= '0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != ST_IDLE);
            dm_start   <= (state_n == ST_START);
            done_valid <= (state_n == ST_DONE);
            // Reaching DONE straight from IDLE means the descriptor was rejected.
            done_err   <= (state == ST_IDLE) && (state_n == ST_DONE);
            if (accept) begin
                rr_ptr  <= IW'((int'(g_idx) + 1) % NREQ);
                done_id <= g_idx;
                if (legal) begin
                    dm_src_address <= sel_src;
                    dm_dst_address <= sel_dst;
                    dm_byte_count  <= sel_count;
                    dm_burst_size  <= sel_burst;
                end
            end
            if ((state == ST_WAIT) && (state_n == ST_DONE)) begin
                moves_done <= moves_done + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a behavioural data_mover model
// and a completion scoreboard.
module tb_move_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 512;
    localparam int IW   = 2;

    logic               clk = 1'b0;
    logic               resetn = 1'b1;
    logic               enable = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_src = '0;
    logic [NREQ*64-1:0] req_dst = '0;
    logic [NREQ*64-1:0] req_count = '0;
    logic [NREQ*13-1:0] req_burst = '0;
    logic               done_valid;
    logic [IW-1:0]      done_id;
    logic               done_err;
    logic [31:0]        moves_done;
    logic               busy;
    logic [63:0]        dm_src_address, dm_dst_address, dm_byte_count;
    logic [12:0]        dm_burst_size;
    logic               dm_start;
    logic               dm_idle;

    move_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .enable         (enable),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_src        (req_src),
        .req_dst        (req_dst),
        .req_count      (req_count),
        .req_burst      (req_burst),
        .done_valid     (done_valid),
        .done_id        (done_id),
        .done_err       (done_err),
        .moves_done     (moves_done),
        .busy           (busy),
        .dm_src_address (dm_src_address),
        .dm_dst_address (dm_dst_address),
        .dm_byte_count  (dm_byte_count),
        .dm_burst_size  (dm_burst_size),
        .dm_start       (dm_start),
        .dm_idle        (dm_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          err;
        logic [63:0] src;
        logic [63:0] dst;
        logic [63:0] cnt;
        logic [12:0] burst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_moves = '0;
    int          mv_lat = 20;
    int          mv_cnt = 0;

    // Mover model: busy for mv_lat cycles after the start pulse.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) mv_cnt <= 0;
        else if (dm_start) mv_cnt <= mv_lat;
        else if (mv_cnt > 0) mv_cnt <= mv_cnt - 1;
    end
    assign dm_idle = (mv_cnt == 0) && !dm_start;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal(input logic [63:0] c, input logic [12:0] b);
        bit pow2;
        pow2 = 1'b0;
        for (int i = 0; i < 13; i++) if (b == 13'(1 << i)) pow2 = 1'b1;
        if (!pow2 || int'(b) < DW/8 || int'(b) > 4096) return 1'b0;
        if (c == 64'd0) return 1'b0;
        if ((c % 64'(b)) != 64'd0) return 1'b0;
        if ((c / 64'(b)) >= 64'h1_0000_0000) return 1'b0;
        return 1'b1;
    endfunction

    // Scoreboard: every completion is matched against the oldest accepted move.
    always @(negedge clk) begin
        if (resetn && done_valid) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 64'(done_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_id", 64'(done_id), 64'(mon_e.id));
                check("done_err", 64'(done_err), 64'(mon_e.err));
                if (!mon_e.err) exp_moves = exp_moves + 32'd1;
                check("moves_done", 64'(moves_done), 64'(exp_moves));
                if (!mon_e.err) begin
                    check("dm_src_hold", dm_src_address, mon_e.src);
                    check("dm_dst_hold", dm_dst_address, mon_e.dst);
                    check("dm_count_hold", dm_byte_count, mon_e.cnt);
                    check("dm_burst_hold", 64'(dm_burst_size), 64'(mon_e.burst));
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [63:0] src, input logic [63:0] dst,
                           input logic [63:0] cnt, input logic [12:0] burst);
        req_src[id*64 +: 64]   = src;
        req_dst[id*64 +: 64]   = dst;
        req_count[id*64 +: 64] = cnt;
        req_burst[id*13 +: 13] = burst;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("return_idle", 64'(busy), 64'd0);
    endtask

    task automatic send(input int id, input logic [63:0] src, input logic [63:0] dst,
                        input logic [63:0] cnt, input logic [12:0] burst);
        bit lg;
        bit got;
        lg = model_legal(cnt, burst);
        @(posedge clk); #1;
        set_req(id, src, dst, cnt, burst);
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = req_ready[id];
        end
        check("ready_onehot", 64'(req_ready), 64'd1 << id);
        if (!got) begin
            req_valid[id] = 1'b0;
            return;
        end
        exp_q.push_back('{id, !lg, src, dst, cnt, burst});
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        check("dm_start_t1", 64'(dm_start), 64'(lg));
        if (lg) begin
            check("dm_src_t1", dm_src_address, src);
            check("dm_dst_t1", dm_dst_address, dst);
            check("dm_count_t1", dm_byte_count, cnt);
            check("dm_burst_t1", 64'(dm_burst_size), 64'(burst));
        end else begin
            check("reject_done_t1", 64'(done_valid), 64'd1);
        end
        wait_idle();
    endtask

    initial begin
        bit got;

        // Reset state
        #2 resetn = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_moves", 64'(moves_done), 64'd0);
        check("rst_dm_start", 64'(dm_start), 64'd0);
        check("rst_dm_count", dm_byte_count, 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        enable = 1'b1;

        // Single legal move from requester 0
        mv_lat = 20;
        send(0, 64'h1000, 64'h8000, 64'd4096, 13'd1024);

        // Rejected descriptors on requesters 1..3 (pointer ends back at 0)
        send(1, 64'h100, 64'h200, 64'd100, 13'd64);
        send(2, 64'h100, 64'h200, 64'd960, 13'd96);
        send(3, 64'h100, 64'h200, 64'd128, 13'd32);

        // Round-robin with all requesters continuously valid
        mv_lat = 3;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 64'h10000 * (i + 1), 64'h20000 * (i + 1), 64'd256 * (i + 1), 13'd64);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int n = 0; n < 100 && !got; n++) begin
                @(negedge clk);
                got = |req_ready;
            end
            check("rr_grant", 64'(req_ready), 64'd1 << (k % NREQ));
            if (!got) break;
            exp_q.push_back('{k % NREQ, 1'b0, 64'h10000 * ((k % NREQ) + 1),
                              64'h20000 * ((k % NREQ) + 1), 64'd256 * ((k % NREQ) + 1), 13'd64});
            @(posedge clk); #1;
            if (k == 4) req_valid = '0;
            @(negedge clk);
            check("rr_dm_src", dm_src_address, 64'h10000 * ((k % NREQ) + 1));
        end
        req_valid = '0;
        wait_idle();

        // Zero-length reject on requester 1
        send(1, 64'h0, 64'h0, 64'd0, 13'd64);

        // Enable gating on requester 2
        @(posedge clk); #1;
        enable = 1'b0;
        set_req(2, 64'h3000, 64'h4000, 64'd512, 13'd128);
        req_valid[2] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("gated_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        check("enable_accept", 64'(req_ready), 64'b0100);
        exp_q.push_back('{2, 1'b0, 64'h3000, 64'h4000, 64'd512, 13'd128});
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_idle();

        // Reset in the middle of WAIT
        mv_lat = 50;
        @(posedge clk); #1;
        set_req(2, 64'h5000, 64'h6000, 64'd1024, 13'd256);
        req_valid[2] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = req_ready[2];
        end
        check("mid_accept", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        exp_q.delete();
        exp_moves = '0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_moves", 64'(moves_done), 64'd0);
        check("mid_rst_dm_src", dm_src_address, 64'd0);
        check("mid_rst_dm_count", dm_byte_count, 64'd0);
        check("mid_rst_dm_burst", 64'(dm_burst_size), 64'd0);
        check("mid_rst_done", 64'(done_valid), 64'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("mid_rst_no_done", 64'(done_valid), 64'd0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        mv_lat = 4;
        set_req(1, 64'h7000, 64'h9000, 64'd2048, 13'd512);
        set_req(3, 64'hA000, 64'hB000, 64'd2048, 13'd512);
        req_valid = 4'b1010;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = |req_ready;
        end
        check("post_rst_ptr0", 64'(req_ready), 64'b0010);
        exp_q.push_back('{1, 1'b0, 64'h7000, 64'h9000, 64'd2048, 13'd512});
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Counter wrap
        @(negedge clk);
        force dut.moves_done = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.moves_done;
        #1;
        check("wrap_preload", 64'(moves_done), 64'hFFFF_FFFF);
        exp_moves = 32'hFFFF_FFFF;
        send(0, 64'hC000, 64'hD000, 64'd8192, 13'd4096);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
